reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: minimum number of cycles both reset outputs are held asserted (legal range 1..255).
REQ-002 Parameter STAGGER_CYCLES, default 8: cycles between mem_reset release and sys_reset release (legal range 1..255).
REQ-003 Parameter DRAIN_TIMEOUT, default 255: maximum cycles spent waiting for drain_ack (legal range 1..255).
REQ-004 Port osc_50, input, 1: sole clock, 50 MHz; all state is updated on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low global reset.
REQ-006 Port reset_req, input, 1: asynchronous level from the reset toggle; 1 = hold the system in reset.
REQ-007 Port drain_ack, input, 1: synchronous to osc_50; downstream confirms it is quiesced.
REQ-008 Port drain_req, output, 1: registered; asks downstream to quiesce before reset is applied.
REQ-009 Port mem_reset, output, 1: registered, active-high reset for memory/peripherals; released first.
REQ-010 Port sys_reset, output, 1: registered, active-high reset for the CPU/datapath; released last.
REQ-011 Port timeout, output, 1: registered, sticky; set when a drain timed out.
REQ-012 Port led, output, 1: registered; equals sys_reset.

Function
REQ-013 reset_req SHALL pass through a 2-flop synchronizer; req_s is the synchronized value.
REQ-014 The FSM SHALL have states RUN, QUIESCE, HOLD, and REL_MEM, with one 8-bit counter shared by all states and cleared on every state entry.
REQ-015 In RUN (mem_reset=0, sys_reset=0, drain_req=0), req_s=1 SHALL move the FSM to QUIESCE and set drain_req=1 on the same edge; drain_req is therefore high on the 3rd rising edge after reset_req is first sampled high.
REQ-016 In QUIESCE, drain_ack=1 SHALL move the FSM to HOLD on the next edge, assert mem_reset and sys_reset, and clear drain_req.
REQ-017 In QUIESCE, if the counter reaches DRAIN_TIMEOUT-1 without drain_ack, the FSM SHALL move to HOLD as in REQ-016 and set timeout.
REQ-018 In QUIESCE, drain_ack and the timeout occurring in the same cycle SHALL count as an ack, so timeout is not set.
REQ-019 A QUIESCE sequence is committed once started: req_s falling during QUIESCE SHALL NOT abort it.
REQ-020 In HOLD, the counter SHALL saturate at HOLD_CYCLES-1, and the FSM SHALL leave HOLD only when the counter equals HOLD_CYCLES-1 and req_s=0.
REQ-021 On leaving HOLD, the FSM SHALL enter REL_MEM and set mem_reset=0 on the same edge.
REQ-022 In REL_MEM, req_s=1 SHALL return the FSM to HOLD, reassert mem_reset, and clear the counter.
REQ-023 In REL_MEM, when the counter reaches STAGGER_CYCLES-1 with req_s=0, the FSM SHALL enter RUN and set sys_reset=0.
REQ-024 sys_reset SHALL never be 0 while mem_reset is 1.
REQ-025 drain_req SHALL be 1 only in QUIESCE.
REQ-026 timeout SHALL be cleared only by reset_n.
REQ-027 drain_ack outside QUIESCE SHALL be ignored.

Reset
REQ-028 While reset_n=0, the block SHALL hold: state HOLD, counter 0, both synchronizer flops 0, mem_reset=1, sys_reset=1, led=1, drain_req=0, timeout=0.
REQ-029 Reset mid-sequence (any state) SHALL force the values of REQ-028 immediately, with no drain handshake.
REQ-030 After reset_n rises, the FSM SHALL run the normal HOLD to REL_MEM to RUN release sequence.

Structure
REQ-031 Package reset_seq_pkg SHALL hold the state enum (RUN, QUIESCE, HOLD, REL_MEM), the default parameter constants, and the counter width (8).
REQ-032 The synchronizer SHALL be the sub-module sync_2ff (1-bit, async active-low reset to 0), instantiated once.

Verification
REQ-033 Power-up: reset_n low then high with reset_req=0 -> mem_reset falls on edge 16 after release, sys_reset falls 8 edges later, and led tracks sys_reset.
REQ-034 Clean drain: in RUN, raise reset_req; drain_ack rises 5 cycles after drain_req -> drain_req=1 from the 3rd edge, both resets assert on the edge after drain_ack, timeout stays 0.
REQ-035 Drain timeout: reset_req=1, drain_ack held 0 -> drain_req stays high for exactly 255 cycles, then the FSM is in HOLD with timeout=1; timeout is still 1 after the next full release.
REQ-036 Long request: reset_req held 1 for 100 cycles after HOLD entry -> resets stay asserted until 2 edges after reset_req falls (synchronizer), then the staggered 8-cycle release follows.
REQ-037 Re-request during stagger: reset_req pulses high 3 cycles into REL_MEM -> mem_reset reasserts, the counter restarts, and a full 16-cycle HOLD occurs before release.
REQ-038 Async reset mid-QUIESCE: reset_n pulsed low while drain_req=1 -> drain_req=0 and both resets=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM states, counter width, default
// timing constants and the per-state decode of the drain/reset outputs.
package reset_seq_pkg;
  localparam int CNT_W              = 8;
  localparam int HOLD_CYCLES_DEF    = 16;
  localparam int STAGGER_CYCLES_DEF = 8;
  localparam int DRAIN_TIMEOUT_DEF  = 255;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    QUIESCE = 2'd1,
    HOLD    = 2'd2,
    REL_MEM = 2'd3
  } state_t;

  typedef struct packed {
    logic drain_req;
    logic mem_reset;
    logic sys_reset;
  } ctrl_t;

  // sys_reset is asserted in a superset of the states that assert mem_reset,
  // so the memory-before-CPU release order cannot be violated.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c.drain_req = (s == QUIESCE);
    c.mem_reset = (s == HOLD);
    c.sys_reset = (s == HOLD) || (s == REL_MEM);
    return c;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: drains downstream logic, holds memory and CPU resets for a
// minimum time, then releases memory first and the CPU a stagger later.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int STAGGER_CYCLES = STAGGER_CYCLES_DEF,
  parameter int DRAIN_TIMEOUT  = DRAIN_TIMEOUT_DEF
) (
  input  logic   osc_50,
  input  logic   reset_n,
  input  logic   reset_req,
  input  logic   drain_ack,
  output logic   drain_req,
  output logic   mem_reset,
  output logic   sys_reset,
  output logic   timeout,
  output logic   led,
  output state_t fsm_state
);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_TIMEOUT - 1);

  logic             req_s;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             drain_expired;
  logic             next_timeout;
  ctrl_t            next_ctrl;

  sync_2ff u_req_sync (
    .clk   (osc_50),
    .rst_n (reset_n),
    .d     (reset_req),
    .q     (req_s)
  );

  assign fsm_state = state;

  always_ff @(posedge osc_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HOLD;
      cnt       <= '0;
      drain_req <= 1'b0;
      mem_reset <= 1'b1;
      sys_reset <= 1'b1;
      led       <= 1'b1;
      timeout   <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      drain_req <= next_ctrl.drain_req;
      mem_reset <= next_ctrl.mem_reset;
      sys_reset <= next_ctrl.sys_reset;
      led       <= next_ctrl.sys_reset;
      timeout   <= next_timeout;
    end
  end

  // Drain handshake: drain_req stays high for all of QUIESCE; drain_ack is only
  // looked at there, and the first cycle it is high completes the handshake.
  // An ack in the same cycle as the timeout wins, so no timeout is flagged.
  always_comb begin
    next_state    = state;
    drain_expired = 1'b0;
    case (state)
      RUN: begin
        if (req_s) next_state = QUIESCE;
      end
      QUIESCE: begin
        if (drain_ack) begin
          next_state = HOLD;
        end else if (cnt == DRAIN_LAST) begin
          next_state    = HOLD;
          drain_expired = 1'b1;
        end
      end
      HOLD: begin
        if ((cnt == HOLD_LAST) && !req_s) next_state = REL_MEM;
      end
      REL_MEM: begin
        if (req_s) next_state = HOLD;
        else if (cnt == STAGGER_LAST) next_state = RUN;
      end
      default: next_state = HOLD;
    endcase

    // The shared counter restarts on every state entry, including HOLD re-entry.
    next_cnt = '0;
    if (next_state == state) begin
      case (state)
        RUN:     next_cnt = '0;
        HOLD:    next_cnt = (cnt == HOLD_LAST) ? cnt : cnt + CNT_W'(1);
        default: next_cnt = cnt + CNT_W'(1);
      endcase
    end

    next_timeout = timeout | drain_expired;
  end

  always_comb begin
    next_ctrl = state_ctrl(next_state);
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed tables and sequences for the release,
// drain, timeout and re-request cases, then random traffic against a model.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int HC = 16;
  localparam int SC = 8;
  localparam int DT = 255;

  logic   osc_50;
  logic   reset_n;
  logic   reset_req;
  logic   drain_ack;
  logic   drain_req;
  logic   mem_reset;
  logic   sys_reset;
  logic   timeout;
  logic   led;
  state_t fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];

  // Model of the observable behaviour: synchronizer pipe plus output flags
  // and the time spent in the current phase.
  logic m_s1, m_s2, m_drain, m_mem, m_sys, m_to;
  int   m_age;

  typedef struct {
    int         at;
    logic [4:0] exp;
  } point_t;

  typedef struct {
    int         n;
    logic       req;
    logic       ack;
    logic [4:0] exp;
  } row_t;

  point_t pu_tab[5];
  row_t   dr_tab[6];

  reset_sequencer #(
    .HOLD_CYCLES    (HC),
    .STAGGER_CYCLES (SC),
    .DRAIN_TIMEOUT  (DT)
  ) dut (
    .osc_50    (osc_50),
    .reset_n   (reset_n),
    .reset_req (reset_req),
    .drain_ack (drain_ack),
    .drain_req (drain_req),
    .mem_reset (mem_reset),
    .sys_reset (sys_reset),
    .timeout   (timeout),
    .led       (led),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial osc_50 = 1'b0;
  always #10 osc_50 = ~osc_50;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_vec(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {drain_req, mem_reset, sys_reset, timeout, led};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got drain/mem/sys/to/led=%b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge osc_50);
    #1;
  endtask

  task automatic power_up(input string name);
    bit done;
    reset_n   = 1'b0;
    reset_req = 1'b0;
    drain_ack = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!sys_reset) done = 1'b1;
    end
    check_int(name, int'(done), 1);
  endtask

  task automatic wait_drain(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = drain_req;
    end
    check_int(name, int'(seen), 1);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0;
    m_drain = 1'b0; m_mem = 1'b1; m_sys = 1'b1; m_to = 1'b0;
    m_age = 0;
  endtask

  task automatic model_edge();
    logic rs;
    rs = m_s2;
    if (m_drain) begin
      if (drain_ack || m_age == DT - 1) begin
        if (!drain_ack) m_to = 1'b1;
        m_drain = 1'b0; m_mem = 1'b1; m_sys = 1'b1; m_age = 0;
      end else begin
        m_age++;
      end
    end else if (m_mem) begin
      if (!rs && m_age >= HC - 1) begin
        m_mem = 1'b0; m_age = 0;
      end else if (m_age < HC - 1) begin
        m_age++;
      end
    end else if (m_sys) begin
      if (rs) begin
        m_mem = 1'b1; m_age = 0;
      end else if (m_age == SC - 1) begin
        m_sys = 1'b0; m_age = 0;
      end else begin
        m_age++;
      end
    end else if (rs) begin
      m_drain = 1'b1; m_age = 0;
    end
    m_s2 = m_s1;
    m_s1 = reset_req;
  endtask

  function automatic logic [4:0] model_vec();
    return {m_drain, m_mem, m_sys, m_to, m_sys};
  endfunction

  task automatic tick_check(input string name);
    @(posedge osc_50);
    if (!reset_n) model_reset();
    else model_edge();
    exp_q.push_back(model_vec());
    #1;
    check_vec(name, exp_q.pop_front());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit         flag;
    int         len;
    int         hold_left;
    int         rst_left;
    int         ack_pct;
    logic [4:0] e;

    pu_tab[0] = '{1,  5'b01101};
    pu_tab[1] = '{15, 5'b01101};
    pu_tab[2] = '{16, 5'b00101};
    pu_tab[3] = '{23, 5'b00101};
    pu_tab[4] = '{24, 5'b00000};

    dr_tab[0] = '{2,  1'b1, 1'b0, 5'b00000};
    dr_tab[1] = '{6,  1'b1, 1'b0, 5'b10000};
    dr_tab[2] = '{1,  1'b0, 1'b1, 5'b01101};
    dr_tab[3] = '{15, 1'b0, 1'b1, 5'b01101};
    dr_tab[4] = '{8,  1'b0, 1'b0, 5'b00101};
    dr_tab[5] = '{2,  1'b0, 1'b0, 5'b00000};

    reset_n   = 1'b0;
    reset_req = 1'b0;
    drain_ack = 1'b0;

    // Reset state
    repeat (3) step();
    check_vec("reset_state", 5'b01101);
    check_int("reset_fsm", int'(fsm_state), int'(HOLD));

    // Power-up release
    reset_n = 1'b1;
    for (int edge_n = 1; edge_n <= 24; edge_n++) begin
      step();
      foreach (pu_tab[r])
        if (pu_tab[r].at == edge_n) check_vec($sformatf("powerup_edge%0d", edge_n), pu_tab[r].exp);
    end

    // Clean drain, ack 5 cycles after drain_req, then release
    foreach (dr_tab[i]) begin
      reset_req = dr_tab[i].req;
      drain_ack = dr_tab[i].ack;
      for (int k = 0; k < dr_tab[i].n; k++) begin
        step();
        check_vec($sformatf("drain_row%0d_cyc%0d", i, k), dr_tab[i].exp);
      end
    end
    reset_req = 1'b0;
    drain_ack = 1'b0;

    // Async reset while draining
    reset_req = 1'b1;
    wait_drain("arst_drain_seen");
    #5 reset_n = 1'b0;
    #1;
    check_vec("arst_immediate", 5'b01101);
    check_int("arst_fsm", int'(fsm_state), int'(HOLD));
    power_up("arst_release");

    // Ack in the same cycle as the timeout counts as an ack
    reset_req = 1'b1;
    wait_drain("coinc_drain_seen");
    repeat (DT - 1) step();
    check_vec("coinc_pre", 5'b10000);
    drain_ack = 1'b1;
    step();
    check_vec("coinc_ack_wins", 5'b01101);
    drain_ack = 1'b0;

    // Long request: hold stays asserted until the synchronized request drops
    repeat (99) step();
    check_vec("long_hold", 5'b01101);
    check_int("long_fsm", int'(fsm_state), int'(HOLD));
    reset_req = 1'b0;
    step();
    step();
    check_vec("long_sync_delay", 5'b01101);
    step();
    check_vec("long_mem_rel", 5'b00101);
    repeat (SC - 1) step();
    check_vec("long_stagger", 5'b00101);
    step();
    check_vec("long_sys_rel", 5'b00000);

    // Drain timeout, sticky flag
    reset_req = 1'b1;
    wait_drain("to_drain_seen");
    len  = 1;
    flag = 1'b0;
    for (int i = 0; i < 400 && !flag; i++) begin
      step();
      if (drain_req) len++;
      else flag = 1'b1;
    end
    check_int("to_len", len, DT);
    check_vec("to_hold", 5'b01111);
    check_int("to_fsm", int'(fsm_state), int'(HOLD));
    reset_req = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 60 && !flag; i++) begin
      step();
      if (!sys_reset) flag = 1'b1;
    end
    check_int("to_release_seen", int'(flag), 1);
    check_vec("to_sticky", 5'b00010);

    // Re-request three cycles into the stagger
    power_up("rereq_pu");
    reset_req = 1'b1;
    wait_drain("rereq_drain_seen");
    drain_ack = 1'b1;
    reset_req = 1'b0;
    step();
    check_vec("rereq_hold", 5'b01101);
    drain_ack = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 40 && !flag; i++) begin
      step();
      if (!mem_reset) flag = 1'b1;
    end
    check_int("rereq_relmem_seen", int'(flag), 1);
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    check_vec("rereq_k1", 5'b00101);
    for (int k = 2; k <= 27; k++) begin
      step();
      if (k < 3)       e = 5'b00101;
      else if (k < 19) e = 5'b01101;
      else if (k < 27) e = 5'b00101;
      else             e = 5'b00000;
      check_vec($sformatf("rereq_k%0d", k), e);
      if (k == 3) check_int("rereq_fsm", int'(fsm_state), int'(HOLD));
    end

    // Random traffic against the model
    reset_n   = 1'b0;
    reset_req = 1'b0;
    drain_ack = 1'b0;
    model_reset();
    tick_check("rand_init");
    tick_check("rand_init");
    reset_n   = 1'b1;
    hold_left = 0;
    rst_left  = 0;
    ack_pct   = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_left == 0) begin
        reset_req = 1'($urandom_range(0, 1));
        hold_left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 320))
                                                : int'($urandom_range(1, 40));
        case ($urandom_range(0, 3))
          0:       ack_pct = 0;
          1:       ack_pct = 5;
          2:       ack_pct = 50;
          default: ack_pct = 100;
        endcase
      end
      hold_left--;
      drain_ack = ($urandom_range(0, 99) < ack_pct);
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #4 reset_n = 1'b0;
        model_reset();
        exp_q.push_back(model_vec());
        #1;
        check_vec("rand_async_rst", exp_q.pop_front());
        rst_left = $urandom_range(1, 3);
      end
      tick_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
